// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen
//   Front-end fetch-address generator. Owns the fetch PC, issues one
//   instruction-SRAM request per accepted cycle (the same address is shown
//   to the BTB), resolves the BTB prediction one cycle later, applies
//   back-end redirects, and keeps an in-order queue of issued fetches
//   (with prediction info and a wrong-path cancel flag) for the IF stage.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   fetch_pc, fetch_en  address and latch strobe towards the BTB
//   btb_ret_*           BTB result for the PC latched in the previous cycle
//   inst_req/addr/ok    instruction SRAM request handshake
//   redirect_en/pc      back-end redirect (highest priority)
//   out_*               head of the issued-fetch queue, popped by out_ready
module fetch_pc_gen #(
    parameter logic [31:0] RESET_PC = 32'h1c00_0000,
    parameter int          QDEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] fetch_pc,
    output logic        fetch_en,
    input  logic        btb_ret_en,
    input  logic        btb_taken,
    input  logic [31:0] btb_ret_pc,
    input  logic [4:0]  btb_ret_index,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic        out_pred_taken,
    output logic [31:0] out_pred_target,
    output logic        out_btb_hit,
    output logic [4:0]  out_btb_index,
    output logic        out_cancel
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH + 1);

    logic [31:0]   pc;
    logic          p1_valid;
    logic [31:0]   p1_pc;
    logic          p1_cancel;

    logic [31:0]   q_pc     [QDEPTH];
    logic          q_taken  [QDEPTH];
    logic [31:0]   q_target [QDEPTH];
    logic          q_hit    [QDEPTH];
    logic [4:0]    q_index  [QDEPTH];
    logic          q_cancel [QDEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic [CW:0]   occupancy;
    logic          room;
    logic          issue;
    logic          push;
    logic          pop;
    logic          res_cancel;
    logic          res_hit;
    logic          res_taken;
    logic          pred_redirect;
    logic          unused_redirect_lsbs;

    // Room counts the entry still sitting in P1, and deliberately ignores a
    // pop in the same cycle so the request never depends on out_ready.
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, p1_valid};
    assign room      = occupancy <= (CW + 1)'(QDEPTH - 1);

    assign inst_req  = !reset && !redirect_en && room;
    assign inst_addr = pc;
    assign fetch_pc  = pc;
    assign issue     = inst_req && inst_addr_ok;
    assign fetch_en  = issue;

    // A redirect in the resolve cycle turns the P1 entry into wrong-path,
    // which also suppresses its prediction.
    assign res_cancel    = p1_cancel || redirect_en;
    assign res_hit       = btb_ret_en && !res_cancel;
    assign res_taken     = res_hit && btb_taken;
    assign pred_redirect = p1_valid && res_taken;

    assign push      = p1_valid;
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            pc        <= RESET_PC;
            p1_valid  <= 1'b0;
            p1_pc     <= '0;
            p1_cancel <= 1'b0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
        end else begin
            if (redirect_en) begin
                pc <= {redirect_pc[31:2], 2'b00};
            end else if (pred_redirect) begin
                pc <= btb_ret_pc;
            end else if (issue) begin
                pc <= pc + 32'd4;
            end

            p1_valid <= issue;
            if (issue) begin
                p1_pc     <= pc;
                // the request issued alongside a taken prediction is the
                // fall-through address and therefore wrong-path
                p1_cancel <= pred_redirect;
            end

            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Queue payload needs no reset: it is only visible through out_valid.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (redirect_en) begin
                for (int i = 0; i < QDEPTH; i++) begin
                    q_cancel[i] <= 1'b1;
                end
            end
            if (push) begin
                q_pc[tail]     <= p1_pc;
                q_taken[tail]  <= res_taken;
                q_target[tail] <= btb_ret_en ? btb_ret_pc : 32'h0;
                q_hit[tail]    <= res_hit;
                q_index[tail]  <= btb_ret_en ? btb_ret_index : 5'd0;
                q_cancel[tail] <= res_cancel;
            end
        end
    end

    always_comb begin
        out_pc          = '0;
        out_pred_taken  = 1'b0;
        out_pred_target = '0;
        out_btb_hit     = 1'b0;
        out_btb_index   = '0;
        out_cancel      = 1'b0;
        if (out_valid) begin
            out_pc          = q_pc[head];
            out_pred_taken  = q_taken[head];
            out_pred_target = q_target[head];
            out_btb_hit     = q_hit[head];
            out_btb_index   = q_index[head];
            out_cancel      = q_cancel[head];
        end
    end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb_fetch_pc_gen
//   Scenario tasks for fetch_pc_gen. Inputs change on the falling edge,
//   outputs are sampled 1 ns later. A behavioural reference tracks the
//   fetch PC and the pending P1 fetch; each resolved fetch pushes its
//   expected queue entry to exp_q, which is popped and compared when the
//   DUT presents and pops its head.
module tb_fetch_pc_gen;

    localparam logic [31:0] RESET_PC = 32'h1c00_0000;
    localparam int          QDEPTH   = 4;

    // {pc, taken, target, hit, index, cancel}
    typedef logic [71:0] ent_t;

    logic        clk;
    logic        reset;
    logic [31:0] fetch_pc;
    logic        fetch_en;
    logic        btb_ret_en;
    logic        btb_taken;
    logic [31:0] btb_ret_pc;
    logic [4:0]  btb_ret_index;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic        out_pred_taken;
    logic [31:0] out_pred_target;
    logic        out_btb_hit;
    logic [4:0]  out_btb_index;
    logic        out_cancel;

    int          checks = 0;
    int          errors = 0;
    string       cur = "";

    ent_t        exp_q[$];
    logic [31:0] m_pc    = RESET_PC;
    logic        m_p1_v  = 1'b0;
    logic [31:0] m_p1_pc = '0;
    logic        m_p1_c  = 1'b0;
    logic        m_req   = 1'b0;

    fetch_pc_gen #(
        .RESET_PC(RESET_PC),
        .QDEPTH  (QDEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_pc       (fetch_pc),
        .fetch_en       (fetch_en),
        .btb_ret_en     (btb_ret_en),
        .btb_taken      (btb_taken),
        .btb_ret_pc     (btb_ret_pc),
        .btb_ret_index  (btb_ret_index),
        .inst_req       (inst_req),
        .inst_addr      (inst_addr),
        .inst_addr_ok   (inst_addr_ok),
        .redirect_en    (redirect_en),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_pred_taken (out_pred_taken),
        .out_pred_target(out_pred_target),
        .out_btb_hit    (out_btb_hit),
        .out_btb_index  (out_btb_index),
        .out_cancel     (out_cancel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of stimulus and derive the expected request.
    task automatic drive(input logic ok, input logic rdy, input logic rd,
                         input logic [31:0] rpc, input logic ben, input logic btk,
                         input logic [31:0] bpc, input logic [4:0] bidx);
        inst_addr_ok  = ok;
        out_ready     = rdy;
        redirect_en   = rd;
        redirect_pc   = rpc;
        btb_ret_en    = ben;
        btb_taken     = btk;
        btb_ret_pc    = bpc;
        btb_ret_index = bidx;
        m_req = !reset && !rd && ((exp_q.size() + int'(m_p1_v)) <= QDEPTH - 1);
    endtask

    // Reference update for the coming rising edge, then wait for the next
    // falling edge.
    task automatic advance();
        ent_t e;
        logic c;
        logic tk;
        logic iss;
        if (reset) begin
            m_pc   = RESET_PC;
            m_p1_v = 1'b0;
            m_p1_c = 1'b0;
            exp_q.delete();
        end else begin
            tk = 1'b0;
            if (redirect_en) begin
                foreach (exp_q[i]) begin
                    e = exp_q[i];
                    e[0] = 1'b1;
                    exp_q[i] = e;
                end
            end
            if (m_p1_v) begin
                c  = m_p1_c || redirect_en;
                tk = btb_ret_en && btb_taken && !c;
                e  = {m_p1_pc, tk, (btb_ret_en ? btb_ret_pc : 32'h0),
                      (btb_ret_en && !c), (btb_ret_en ? btb_ret_index : 5'd0), c};
                exp_q.push_back(e);
            end
            iss     = m_req && inst_addr_ok;
            m_p1_v  = iss;
            m_p1_pc = m_pc;
            m_p1_c  = tk;
            if (redirect_en)  m_pc = {redirect_pc[31:2], 2'b00};
            else if (tk)      m_pc = btb_ret_pc;
            else if (iss)     m_pc = m_pc + 32'd4;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 5'd0);
        #1;
        advance();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        cur = "reset";
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 5'd0);
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({inst_req, fetch_en, out_valid} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: req/en/valid got %b expected 000", {inst_req, fetch_en, out_valid});
        end
        checks++;
        if ({out_pc, out_pred_taken, out_pred_target, out_btb_hit, out_btb_index, out_cancel} !== 72'd0) begin
            errors++;
            $display("FAIL reset_out_data: got nonzero %h expected 0",
                     {out_pc, out_pred_taken, out_pred_target, out_btb_hit, out_btb_index, out_cancel});
        end
        checks++;
        if (inst_addr !== RESET_PC || fetch_pc !== RESET_PC) begin
            errors++;
            $display("FAIL reset_pc: inst_addr=%h fetch_pc=%h expected %h", inst_addr, fetch_pc, RESET_PC);
        end
        m_pc   = RESET_PC;
        m_p1_v = 1'b0;
        exp_q.delete();
        reset = 1'b0;
        #1;
        checks++;
        if (inst_req !== 1'b1) begin
            errors++;
            $display("FAIL first_req: inst_req=%b expected 1", inst_req);
        end
        @(negedge clk);
    endtask

    task automatic test_sequential();
        cur = "sequential";
        for (int c = 0; c < 8; c++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 5'd0);
            #1;
            checks++;
            if ({inst_req, fetch_en, inst_addr, fetch_pc} !== {m_req, m_req && inst_addr_ok, m_pc, m_pc}) begin
                errors++;
                $display("FAIL %s fetch c%0d: got req=%b en=%b addr=%h fpc=%h, expected req=%b en=%b addr=%h",
                         cur, c, inst_req, fetch_en, inst_addr, fetch_pc, m_req, m_req && inst_addr_ok, m_pc);
            end
            checks++;
            if (exp_q.size() == 0) begin
                if ({out_valid, out_pc, out_pred_taken, out_pred_target, out_btb_hit, out_btb_index, out_cancel} !== 73'd0) begin
                    errors++;
                    $display("FAIL %s empty_head c%0d: got valid=%b pc=%h, expected all zero", cur, c, out_valid, out_pc);
                end
            end else begin
                if ({out_valid, out_pc, out_pred_taken, out_pred_target, out_btb_hit, out_btb_index, out_cancel} !== {1'b1, exp_q[0]}) begin
                    errors++;
                    $display("FAIL %s head c%0d: got %h expected %h", cur, c,
                             {out_valid, out_pc, out_pred_taken, out_pred_target, out_btb_hit, out_btb_index, out_cancel}, {1'b1, exp_q[0]});
                end
                if (out_ready) void'(exp_q.pop_front());
            end
            if (c < 3) begin
                checks++;
                if (inst_addr !== RESET_PC + 32'(4 * c)) begin
                    errors++;
                    $display("FAIL seq_addr c%0d: got %h expected %h", c, inst_addr, RESET_PC + 32'(4 * c));
                end
            end
            if (c >= 2) begin
                checks++;
                if ({out_valid, out_pc, out_cancel, out_btb_hit} !== {1'b1, RESET_PC + 32'(4 * (c - 2)), 2'b00}) begin
                    errors++;
                    $display("FAIL seq_head c%0d: got valid=%b pc=%h cancel=%b hit=%b expected 1 %h 0 0",
                             c, out_valid, out_pc, out_cancel, out_btb_hit, RESET_PC + 32'(4 * (c - 2)));
                end
            end
            advance();
        end
    endtask

    task automatic test_btb_taken();
        cur = "btb_taken";
        do_reset();
        for (int c = 0; c < 8; c++) begin
            if (c == 2) drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h1c00_0100, 5'd7);
            else        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 5'd0);
            #1;
            checks++;
            if ({inst_req, fetch_en, inst_addr, fetch_pc} !== {m_req, m_req && inst_addr_ok, m_pc, m_pc}) begin
                errors++;
                $display("FAIL %s fetch c%0d: got req=%b en=%b addr=%h fpc=%h, expected req=%b en=%b addr=%h",
                         cur, c, inst_req, fetch_en, inst_addr, fetch_pc, m_req, m_req && inst_addr_ok, m_pc);
            end
            checks++;
            if (exp_q.size() == 0) begin
                if ({out_valid, out_pc, out_pred_taken, out_pred_target, out_btb_hit, out_btb_index, out_cancel} !== 73'd0) begin
                    errors++;
                    $display("FAIL %s empty_head c%0d: got valid=%b pc=%h, expected all zero", cur, c, out_valid, out_pc);
                end
            end else begin
                if ({out_valid, out_pc, out_pred_taken, out_pred_target, out_btb_hit, out_btb_index, out_cancel} !== {1'b1, exp_q[0]}) begin
                    errors++;
                    $display("FAIL %s head c%0d: got %h expected %h", cur, c,
                             {out_valid, out_pc, out_pred_taken, out_pred_target, out_btb_hit, out_btb_index, out_cancel}, {1'b1, exp_q[0]});
                end
                if (out_ready) void'(exp_q.pop_front());
            end
            if (c == 3) begin
                checks++;
                if (inst_addr !== 32'h1c00_0100) begin
                    errors++;
                    $display("FAIL taken_next_issue: got %h expected 1c000100", inst_addr);
                end
                checks++;
                if ({out_pc, out_pred_taken, out_pred_target, out_btb_hit, out_btb_index, out_cancel} !==
                    {32'h1c00_0004, 1'b1, 32'h1c00_0100, 1'b1, 5'd7, 1'b0}) begin
                    errors++;
                    $display("FAIL taken_entry: got pc=%h tk=%b tgt=%h hit=%b idx=%0d cancel=%b expected 1c000004 1 1c000100 1 7 0",
                             out_pc, out_pred_taken, out_pred_target, out_btb_hit, out_btb_index, out_cancel);
                end
            end
            if (c == 4) begin
                checks++;
                if ({out_pc, out_cancel} !== {32'h1c00_0008, 1'b1}) begin
                    errors++;
                    $display("FAIL wrong_path_entry: got pc=%h cancel=%b expected 1c000008 1", out_pc, out_cancel);
                end
            end
            advance();
        end
    endtask

    task automatic test_backpressure();
        int n_full;
        int n_one;
        n_full = 0;
        n_one  = 0;
        cur = "backpressure";
        for (int c = 0; c < 20; c++) begin
            if (c < 6)        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 5'd0);
            else if (c == 14) drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 5'd0);
            else              drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 5'd0);
            #1;
            checks++;
            if ({inst_req, fetch_en, inst_addr, fetch_pc} !== {m_req, m_req && inst_addr_ok, m_pc, m_pc}) begin
                errors++;
                $display("FAIL %s fetch c%0d: got req=%b en=%b addr=%h fpc=%h, expected req=%b en=%b addr=%h",
                         cur, c, inst_req, fetch_en, inst_addr, fetch_pc, m_req, m_req && inst_addr_ok, m_pc);
            end
            checks++;
            if (exp_q.size() == 0) begin
                if ({out_valid, out_pc, out_pred_taken, out_pred_target, out_btb_hit, out_btb_index, out_cancel} !== 73'd0) begin
                    errors++;
                    $display("FAIL %s empty_head c%0d: got valid=%b pc=%h, expected all zero", cur, c, out_valid, out_pc);
                end
            end else begin
                if ({out_valid, out_pc, out_pred_taken, out_pred_target, out_btb_hit, out_btb_index, out_cancel} !== {1'b1, exp_q[0]}) begin
                    errors++;
                    $display("FAIL %s head c%0d: got %h expected %h", cur, c,
                             {out_valid, out_pc, out_pred_taken, out_pred_target, out_btb_hit, out_btb_index, out_cancel}, {1'b1, exp_q[0]});
                end
                if (out_ready) void'(exp_q.pop_front());
            end
            if (c >= 6 && c < 14 && fetch_en === 1'b1) n_full++;
            if (c >= 14 && fetch_en === 1'b1) n_one++;
            if (c == 13) begin
                checks++;
                if (inst_req !== 1'b0) begin
                    errors++;
                    $display("FAIL full_req_low: inst_req=%b expected 0", inst_req);
                end
            end
            advance();
        end
        checks++;
        if (n_full !== QDEPTH) begin
            errors++;
            $display("FAIL full_issue_count: got %0d issues expected %0d", n_full, QDEPTH);
        end
        checks++;
        if (n_one !== 1) begin
            errors++;
            $display("FAIL one_pop_one_issue: got %0d issues expected 1", n_one);
        end
    endtask

    task automatic test_redirect();
        int n_canc;
        n_canc = 0;
        cur = "redirect";
        for (int c = 0; c < 16; c++) begin
            if (c < 6)        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 5'd0);
            else if (c < 9)   drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 5'd0);
            else if (c < 11)  drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 5'd0);
            else if (c == 11) drive(1'b1, 1'b0, 1'b1, 32'h1c00_0203, 1'b0, 1'b0, 32'h0, 5'd0);
            else              drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 5'd0);
            #1;
            checks++;
            if ({inst_req, fetch_en, inst_addr, fetch_pc} !== {m_req, m_req && inst_addr_ok, m_pc, m_pc}) begin
                errors++;
                $display("FAIL %s fetch c%0d: got req=%b en=%b addr=%h fpc=%h, expected req=%b en=%b addr=%h",
                         cur, c, inst_req, fetch_en, inst_addr, fetch_pc, m_req, m_req && inst_addr_ok, m_pc);
            end
            checks++;
            if (exp_q.size() == 0) begin
                if ({out_valid, out_pc, out_pred_taken, out_pred_target, out_btb_hit, out_btb_index, out_cancel} !== 73'd0) begin
                    errors++;
                    $display("FAIL %s empty_head c%0d: got valid=%b pc=%h, expected all zero", cur, c, out_valid, out_pc);
                end
            end else begin
                if ({out_valid, out_pc, out_pred_taken, out_pred_target, out_btb_hit, out_btb_index, out_cancel} !== {1'b1, exp_q[0]}) begin
                    errors++;
                    $display("FAIL %s head c%0d: got %h expected %h", cur, c,
                             {out_valid, out_pc, out_pred_taken, out_pred_target, out_btb_hit, out_btb_index, out_cancel}, {1'b1, exp_q[0]});
                end
                if (out_ready) void'(exp_q.pop_front());
            end
            if (c == 11) begin
                checks++;
                if (inst_req !== 1'b0) begin
                    errors++;
                    $display("FAIL redirect_req: inst_req=%b expected 0", inst_req);
                end
            end
            if (c == 12) begin
                checks++;
                if (inst_addr !== 32'h1c00_0200) begin
                    errors++;
                    $display("FAIL redirect_addr: got %h expected 1c000200", inst_addr);
                end
            end
            if (c >= 12 && c <= 14 && out_valid === 1'b1 && out_cancel === 1'b1) n_canc++;
            advance();
        end
        checks++;
        if (n_canc !== 3) begin
            errors++;
            $display("FAIL redirect_cancel_count: got %0d cancelled pops expected 3", n_canc);
        end
    endtask

    task automatic test_redirect_vs_taken();
        cur = "redirect_vs_taken";
        for (int c = 0; c < 12; c++) begin
            if (c < 6)       drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 5'd0);
            else if (c == 6) drive(1'b1, 1'b1, 1'b1, 32'h1c00_0400, 1'b0, 1'b0, 32'h0, 5'd0);
            else if (c == 8) drive(1'b1, 1'b1, 1'b1, 32'h1c00_0600, 1'b1, 1'b1, 32'h1c00_0800, 5'd3);
            else             drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 5'd0);
            #1;
            checks++;
            if ({inst_req, fetch_en, inst_addr, fetch_pc} !== {m_req, m_req && inst_addr_ok, m_pc, m_pc}) begin
                errors++;
                $display("FAIL %s fetch c%0d: got req=%b en=%b addr=%h fpc=%h, expected req=%b en=%b addr=%h",
                         cur, c, inst_req, fetch_en, inst_addr, fetch_pc, m_req, m_req && inst_addr_ok, m_pc);
            end
            checks++;
            if (exp_q.size() == 0) begin
                if ({out_valid, out_pc, out_pred_taken, out_pred_target, out_btb_hit, out_btb_index, out_cancel} !== 73'd0) begin
                    errors++;
                    $display("FAIL %s empty_head c%0d: got valid=%b pc=%h, expected all zero", cur, c, out_valid, out_pc);
                end
            end else begin
                if ({out_valid, out_pc, out_pred_taken, out_pred_target, out_btb_hit, out_btb_index, out_cancel} !== {1'b1, exp_q[0]}) begin
                    errors++;
                    $display("FAIL %s head c%0d: got %h expected %h", cur, c,
                             {out_valid, out_pc, out_pred_taken, out_pred_target, out_btb_hit, out_btb_index, out_cancel}, {1'b1, exp_q[0]});
                end
                if (out_ready) void'(exp_q.pop_front());
            end
            if (c == 9) begin
                checks++;
                if (inst_addr !== 32'h1c00_0600) begin
                    errors++;
                    $display("FAIL redirect_wins_addr: got %h expected 1c000600", inst_addr);
                end
                checks++;
                if ({out_valid, out_pc, out_pred_taken, out_btb_hit, out_cancel} !== {1'b1, 32'h1c00_0400, 3'b001}) begin
                    errors++;
                    $display("FAIL redirect_wins_entry: got valid=%b pc=%h tk=%b hit=%b cancel=%b expected 1 1c000400 0 0 1",
                             out_valid, out_pc, out_pred_taken, out_btb_hit, out_cancel);
                end
            end
            advance();
        end
    endtask

    task automatic test_wrap();
        cur = "wrap";
        for (int c = 0; c < 5; c++) begin
            if (c == 0) drive(1'b1, 1'b1, 1'b1, 32'hffff_fffe, 1'b0, 1'b0, 32'h0, 5'd0);
            else        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 5'd0);
            #1;
            checks++;
            if ({inst_req, fetch_en, inst_addr, fetch_pc} !== {m_req, m_req && inst_addr_ok, m_pc, m_pc}) begin
                errors++;
                $display("FAIL %s fetch c%0d: got req=%b en=%b addr=%h fpc=%h, expected req=%b en=%b addr=%h",
                         cur, c, inst_req, fetch_en, inst_addr, fetch_pc, m_req, m_req && inst_addr_ok, m_pc);
            end
            checks++;
            if (exp_q.size() == 0) begin
                if ({out_valid, out_pc, out_pred_taken, out_pred_target, out_btb_hit, out_btb_index, out_cancel} !== 73'd0) begin
                    errors++;
                    $display("FAIL %s empty_head c%0d: got valid=%b pc=%h, expected all zero", cur, c, out_valid, out_pc);
                end
            end else begin
                if ({out_valid, out_pc, out_pred_taken, out_pred_target, out_btb_hit, out_btb_index, out_cancel} !== {1'b1, exp_q[0]}) begin
                    errors++;
                    $display("FAIL %s head c%0d: got %h expected %h", cur, c,
                             {out_valid, out_pc, out_pred_taken, out_pred_target, out_btb_hit, out_btb_index, out_cancel}, {1'b1, exp_q[0]});
                end
                if (out_ready) void'(exp_q.pop_front());
            end
            if (c == 1) begin
                checks++;
                if (inst_addr !== 32'hffff_fffc) begin
                    errors++;
                    $display("FAIL wrap_top: got %h expected fffffffc", inst_addr);
                end
            end
            if (c == 2) begin
                checks++;
                if (inst_addr !== 32'h0000_0000) begin
                    errors++;
                    $display("FAIL wrap_zero: got %h expected 00000000", inst_addr);
                end
            end
            advance();
        end
    endtask

    task automatic test_addr_hold();
        cur = "addr_hold";
        for (int c = 0; c < 9; c++) begin
            if (c == 0)     drive(1'b0, 1'b1, 1'b1, 32'h1c00_0300, 1'b0, 1'b0, 32'h0, 5'd0);
            else if (c < 6) drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 5'd0);
            else            drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 5'd0);
            #1;
            checks++;
            if ({inst_req, fetch_en, inst_addr, fetch_pc} !== {m_req, m_req && inst_addr_ok, m_pc, m_pc}) begin
                errors++;
                $display("FAIL %s fetch c%0d: got req=%b en=%b addr=%h fpc=%h, expected req=%b en=%b addr=%h",
                         cur, c, inst_req, fetch_en, inst_addr, fetch_pc, m_req, m_req && inst_addr_ok, m_pc);
            end
            checks++;
            if (exp_q.size() == 0) begin
                if ({out_valid, out_pc, out_pred_taken, out_pred_target, out_btb_hit, out_btb_index, out_cancel} !== 73'd0) begin
                    errors++;
                    $display("FAIL %s empty_head c%0d: got valid=%b pc=%h, expected all zero", cur, c, out_valid, out_pc);
                end
            end else begin
                if ({out_valid, out_pc, out_pred_taken, out_pred_target, out_btb_hit, out_btb_index, out_cancel} !== {1'b1, exp_q[0]}) begin
                    errors++;
                    $display("FAIL %s head c%0d: got %h expected %h", cur, c,
                             {out_valid, out_pc, out_pred_taken, out_pred_target, out_btb_hit, out_btb_index, out_cancel}, {1'b1, exp_q[0]});
                end
                if (out_ready) void'(exp_q.pop_front());
            end
            if (c >= 1 && c <= 5) begin
                checks++;
                if ({inst_req, fetch_en, inst_addr} !== {2'b10, 32'h1c00_0300}) begin
                    errors++;
                    $display("FAIL hold_c%0d: got req=%b en=%b addr=%h expected 1 0 1c000300", c, inst_req, fetch_en, inst_addr);
                end
            end
            if (c == 7) begin
                checks++;
                if (inst_addr !== 32'h1c00_0304) begin
                    errors++;
                    $display("FAIL hold_release: got %h expected 1c000304", inst_addr);
                end
            end
            advance();
        end
    endtask

    task automatic test_mid_reset();
        cur = "mid_reset";
        for (int c = 0; c < 8; c++) begin
            reset = (c == 4);
            if (c < 5) drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 5'd0);
            else       drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 5'd0);
            #1;
            checks++;
            if ({inst_req, fetch_en, inst_addr, fetch_pc} !== {m_req, m_req && inst_addr_ok, m_pc, m_pc}) begin
                errors++;
                $display("FAIL %s fetch c%0d: got req=%b en=%b addr=%h fpc=%h, expected req=%b en=%b addr=%h",
                         cur, c, inst_req, fetch_en, inst_addr, fetch_pc, m_req, m_req && inst_addr_ok, m_pc);
            end
            checks++;
            if (exp_q.size() == 0) begin
                if ({out_valid, out_pc, out_pred_taken, out_pred_target, out_btb_hit, out_btb_index, out_cancel} !== 73'd0) begin
                    errors++;
                    $display("FAIL %s empty_head c%0d: got valid=%b pc=%h, expected all zero", cur, c, out_valid, out_pc);
                end
            end else begin
                if ({out_valid, out_pc, out_pred_taken, out_pred_target, out_btb_hit, out_btb_index, out_cancel} !== {1'b1, exp_q[0]}) begin
                    errors++;
                    $display("FAIL %s head c%0d: got %h expected %h", cur, c,
                             {out_valid, out_pc, out_pred_taken, out_pred_target, out_btb_hit, out_btb_index, out_cancel}, {1'b1, exp_q[0]});
                end
                if (out_ready) void'(exp_q.pop_front());
            end
            if (c == 4) begin
                checks++;
                if (inst_req !== 1'b0) begin
                    errors++;
                    $display("FAIL mid_reset_req: inst_req=%b expected 0", inst_req);
                end
            end
            if (c == 5) begin
                checks++;
                if ({out_valid, out_pc, inst_req, inst_addr} !== {1'b0, 32'h0, 1'b1, RESET_PC}) begin
                    errors++;
                    $display("FAIL mid_reset_flush: got valid=%b out_pc=%h req=%b addr=%h expected 0 0 1 %h",
                             out_valid, out_pc, inst_req, inst_addr, RESET_PC);
                end
            end
            advance();
        end
        reset = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        inst_addr_ok  = 1'b0;
        out_ready     = 1'b0;
        redirect_en   = 1'b0;
        redirect_pc   = '0;
        btb_ret_en    = 1'b0;
        btb_taken     = 1'b0;
        btb_ret_pc    = '0;
        btb_ret_index = '0;
        test_reset();
        test_sequential();
        test_btb_taken();
        test_backpressure();
        test_redirect();
        test_redirect_vs_taken();
        test_wrap();
        test_addr_hold();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_pc_gen.md
# fetch_pc_gen

Front-end fetch-address generator sitting directly upstream of the BTB and the instruction SRAM request port. It owns the architectural fetch PC and issues one fetch request per accepted cycle, presenting the same address to the BTB via `fetch_pc`/`fetch_en`. It consumes the BTB prediction one cycle later and steers the next PC to the predicted target. It also applies back-end redirects and hands an in-order queue of issued fetches, each with its prediction tag and a cancel flag, to the IF stage.

## Interface
- `RESET_PC`, 32'h1c00_0000, first fetch address after reset
- `QDEPTH`, 4, depth of the issued-fetch queue (power of two, ≥2)

- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `fetch_pc`  out  32  address presented to BTB; equals `inst_addr`
- `fetch_en`  out  1  BTB latch strobe; equals `inst_req && inst_addr_ok`
- `btb_ret_en`  in  1  BTB hit for the PC latched last cycle
- `btb_taken`  in  1  BTB counter MSB
- `btb_ret_pc`  in  32  BTB predicted target
- `btb_ret_index`  in  5  BTB hit entry index
- `inst_req`  out  1  instruction SRAM request
- `inst_addr`  out  32  instruction SRAM address
- `inst_addr_ok`  in  1  SRAM accepted the request this cycle
- `redirect_en`  in  1  back-end redirect (mispredict or exception)
- `redirect_pc`  in  32  redirect target; bits [1:0] ignored and forced to 0
- `out_valid`  out  1  queue head valid
- `out_ready`  in  1  IF stage pops the head
- `out_pc`  out  32  head fetch PC
- `out_pred_taken`  out  1  head predicted taken (hit && taken)
- `out_pred_target`  out  32  head predicted target (0 if not hit)
- `out_btb_hit`  out  1  head BTB hit
- `out_btb_index`  out  5  head BTB index
- `out_cancel`  out  1  head is wrong-path; IF discards its instruction data

## Operation
- State: `pc` (32), P1 slot {`p1_valid`, `p1_pc`, `p1_cancel`}, a circular queue of QDEPTH entries {pc, taken, target, hit, index, cancel}, and the queue count.
- `room` is `count + p1_valid <= QDEPTH-1`. This check is conservative and ignores a same-cycle pop.
- `inst_req` is `!reset && !redirect_en && room`. `inst_addr = fetch_pc = pc`.
- Issue: when `inst_req && inst_addr_ok`, P1 loads {pc, cancel=0} and `pc <= pc + 4` (mod 2^32).
- Resolve: when `p1_valid`, BTB outputs refer to `p1_pc`, and the entry is pushed into the queue that cycle.
  - `taken = btb_ret_en && btb_taken && !p1_cancel`.
  - `target = btb_ret_en ? btb_ret_pc : 0`.
  - `hit = btb_ret_en && !p1_cancel`.
  - `index = btb_ret_en ? btb_ret_index : 0`.
  - The entry's cancel field is `p1_cancel`.
- Predicted redirect: if resolve gives `taken`, then `pc <= btb_ret_pc`, overriding pc+4. Any request accepted in the same cycle enters P1 with `p1_cancel = 1`.
- Back-end redirect (highest priority):
  - `pc <= {redirect_pc[31:2], 2'b00}`.
  - Every valid queue entry's cancel field is set.
  - P1, if valid, is still pushed, with cancel=1.
  - No request is issued that cycle.
  - BTB prediction is ignored that cycle.
- Pop: `out_valid && out_ready` advances the head. Push and pop in the same cycle leave `count` unchanged.
- Queue outputs are driven from the head entry. When empty, `out_valid = 0` and the other out fields are 0.

## Timing
- Reset values:
  - `pc = RESET_PC`, `p1_valid = 0`, count 0.
  - `inst_req = 0`, `fetch_en = 0`, `out_valid = 0`, all out data 0.
  - `fetch_pc = inst_addr = RESET_PC`.
- First request: `inst_req = 1` in the first cycle after `reset` deasserts.
- Issue-to-queue latency: issued in cycle t, pushed at the end of t+1, visible as head no earlier than t+2.
- Throughput: one issue per cycle while `inst_addr_ok` is held high and room exists.
  - Each predicted-taken hit costs exactly one cancelled (wrong-path) issue.
  - When issue stops for lack of room, `inst_req` stays low until the queue drains below the room threshold.
- `inst_addr` must not change while `inst_req = 1 && !inst_addr_ok`, except on redirect. On redirect `inst_req` drops for that cycle.
- Reset mid-operation: the queue and P1 are flushed with no outputs. Outstanding SRAM responses are the IF stage's responsibility.
- Same-cycle redirect and predicted-taken: the redirect wins, and the resolved entry is pushed with cancel=1.

## Test plan
- Reset release, `inst_addr_ok = 1`, BTB miss, `out_ready = 1`:
  - Required response: `inst_addr` is 1c000000, 1c000004, 1c000008 on consecutive cycles.
  - Queue heads appear in order, each with cancel=0 and hit=0.
- BTB hit taken at PC 1c000004 with `btb_ret_pc = 1c000100`:
  - Required response: entry for 1c000004 has taken=1, target=1c000100.
  - Entry for 1c000008 has cancel=1.
  - The next issue is 1c000100.
- `out_ready = 0`, continuous `inst_addr_ok`:
  - Required response: exactly QDEPTH issues, then `inst_req = 0`.
  - Asserting `out_ready` for one cycle allows exactly one new issue.
- `redirect_en` with `redirect_pc = 1c000203` while 3 entries are queued:
  - Required response: all 3 entries pop with cancel=1.
  - `inst_req = 0` in the redirect cycle.
  - The next `inst_addr` is 1c000200.
- Redirect in the same cycle as a BTB taken hit: the redirect target is used, and the resolved entry has cancel=1, taken=0.
- Redirect to ffff_fffc, miss: the next issue after ffff_fffc is 0000_0000 (wrap).
- `inst_addr_ok = 0` for 5 cycles: `inst_addr` holds steady and `fetch_en = 0` throughout.
